dma_stream_engine: RTL and testbench

//   Initiator side of the arbiter's DMA port, and AXI-Stream master/slave toward the accelerator.

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_stream_engine_if.sv | 38 +++
 rtl/dma_rd_fifo.sv | 52 +++++
 rtl/dma_stream_engine.sv | 157 +++++++++++++++
 tb/tb_dma_stream_engine.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared widths and FSM encoding for the DMA stream engine.
// Word-addressed BRAM, 32-bit data path.
package dma_pkg;

    localparam int BRAM_AW = 13;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dma_stream_engine_if.sv
// Arbiter DMA port plus both AXI-Stream directions toward the accelerator.
// master = engine side, slave = arbiter/BRAM and accelerator side.
interface dma_stream_engine_if;
    import dma_pkg::*;

    logic               dma_r_ready;
    logic [BRAM_AW-1:0] dma_r_addr;
    logic               dma_r_ack;
    logic               dma_in_valid;
    logic [DATA_W-1:0]  brc_u0_data_o;
    logic               dma_w_valid;
    logic [BRAM_AW-1:0] dma_w_addr;
    logic [DATA_W-1:0]  dma_w_data;

    logic               sm_tvalid;
    logic [DATA_W-1:0]  sm_tdata;
    logic               sm_tlast;
    logic               sm_tready;
    logic               ss_tvalid;
    logic [DATA_W-1:0]  ss_tdata;
    logic               ss_tlast;
    logic               ss_tready;

    modport master (
        output dma_r_ready, dma_r_addr, dma_w_valid, dma_w_addr, dma_w_data,
        output sm_tvalid, sm_tdata, sm_tlast, ss_tready,
        input  dma_r_ack, dma_in_valid, brc_u0_data_o,
        input  sm_tready, ss_tvalid, ss_tdata, ss_tlast
    );

    modport slave (
        input  dma_r_ready, dma_r_addr, dma_w_valid, dma_w_addr, dma_w_data,
        input  sm_tvalid, sm_tdata, sm_tlast, ss_tready,
        output dma_r_ack, dma_in_valid, brc_u0_data_o,
        output sm_tready, ss_tvalid, ss_tdata, ss_tlast
    );

endinterface

// File: rtl/dma_rd_fifo.sv
// Read-return buffer: synchronous FIFO with occupancy count.
// The issue logic upstream guarantees no push when full.
module dma_rd_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dma_stream_engine.sv
// DMA stream engine: BRAM -> sm_* stream and ss_* stream -> BRAM via the arbiter DMA port.
//   state   | meaning
//   IDLE    | waiting for cfg_start
//   RUN     | TX reads/stream and RX stream/writes in flight
//   DONE    | one-cycle completion, done asserted
module dma_stream_engine
    import dma_pkg::*;
#(
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cfg_start,
    input  logic [BRAM_AW-1:0]   cfg_src_base,
    input  logic [BRAM_AW-1:0]   cfg_dst_base,
    input  logic [LEN_W-1:0]     cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err_tlast,
    dma_stream_engine_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dma_state_e          state_q, state_d;
    logic [BRAM_AW-1:0]  rd_addr_q, dst_base_q, w_addr_q;
    logic [LEN_W-1:0]    len_q, req_left_q, tx_count_q, rx_count_q;
    logic [CW-1:0]       outstanding_q, fifo_count;
    logic [CW:0]         occupancy;
    logic [DATA_W-1:0]   w_data_q, fifo_head;
    logic                r_ready_q, r_ready_d, w_valid_q, err_q, fifo_empty;
    logic                start_ok, in_run, ack, rd_ret, tx_valid, tx_beat, rx_beat;
    logic                tx_done, rx_done, rx_is_last;

    assign start_ok   = cfg_start && (state_q == ST_IDLE);
    assign in_run     = (state_q == ST_RUN);
    assign ack        = r_ready_q && bus.dma_r_ack;
    assign rd_ret     = bus.dma_in_valid && in_run;
    assign tx_valid   = in_run && !fifo_empty;
    assign tx_beat    = tx_valid && bus.sm_tready;
    assign rx_beat    = bus.ss_tvalid && bus.ss_tready;
    assign tx_done    = (tx_count_q == len_q);
    assign rx_done    = (rx_count_q == len_q);
    assign rx_is_last = (rx_count_q == len_q - LEN_W'(1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_start) state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (tx_done && rx_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A request in the ack cycle already counts as outstanding, so the FIFO can never overflow.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(outstanding_q) + (CW+1)'(ack);

    always_comb begin
        r_ready_d = 1'b0;
        if (in_run) begin
            if (r_ready_q && !bus.dma_r_ack) begin
                r_ready_d = 1'b1;
            end else begin
                r_ready_d = ((req_left_q - LEN_W'(ack)) != '0) &&
                            (occupancy < (CW+1)'(FIFO_DEPTH));
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ready_q     <= 1'b0;
            rd_addr_q     <= '0;
            dst_base_q    <= '0;
            len_q         <= '0;
            req_left_q    <= '0;
            tx_count_q    <= '0;
            rx_count_q    <= '0;
            outstanding_q <= '0;
            w_valid_q     <= 1'b0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            r_ready_q <= r_ready_d;
            w_valid_q <= 1'b0;
            if (start_ok) begin
                rd_addr_q     <= cfg_src_base;
                dst_base_q    <= cfg_dst_base;
                len_q         <= cfg_len;
                req_left_q    <= cfg_len;
                tx_count_q    <= '0;
                rx_count_q    <= '0;
                outstanding_q <= '0;
                err_q         <= 1'b0;
            end else begin
                if (ack) begin
                    rd_addr_q  <= rd_addr_q + BRAM_AW'(1);
                    req_left_q <= req_left_q - LEN_W'(1);
                end
                case ({ack, rd_ret})
                    2'b10:   outstanding_q <= outstanding_q + CW'(1);
                    2'b01:   outstanding_q <= outstanding_q - CW'(1);
                    default: outstanding_q <= outstanding_q;
                endcase
                if (tx_beat) begin
                    tx_count_q <= tx_count_q + LEN_W'(1);
                end
                if (rx_beat) begin
                    rx_count_q <= rx_count_q + LEN_W'(1);
                    w_valid_q  <= 1'b1;
                    w_addr_q   <= dst_base_q + BRAM_AW'(rx_count_q);
                    w_data_q   <= bus.ss_tdata;
                    if (bus.ss_tlast != rx_is_last) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    dma_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rd_ret),
        .pop   (tx_beat),
        .din   (bus.brc_u0_data_o),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.dma_r_ready = r_ready_q;
    assign bus.dma_r_addr  = rd_addr_q;
    assign bus.dma_w_valid = w_valid_q;
    assign bus.dma_w_addr  = w_addr_q;
    assign bus.dma_w_data  = w_data_q;
    assign bus.sm_tvalid   = tx_valid;
    assign bus.sm_tdata    = tx_valid ? fifo_head : '0;
    assign bus.sm_tlast    = tx_valid && (tx_count_q == len_q - LEN_W'(1));
    assign bus.ss_tready   = in_run && !rx_done;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err_tlast = err_q;

endmodule

// File: tb/tb_dma_stream_engine.sv
// Directed bench for dma_stream_engine: BRAM/arbiter responder and accelerator
// streams driven each negedge, results compared against hand-derived addresses/data.
module tb_dma_stream_engine;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start;
    logic [12:0] cfg_src_base, cfg_dst_base, cfg_len;
    logic        busy, done, err_tlast;

    always #5 clk = ~clk;

    dma_stream_engine_if bus();

    dma_stream_engine #(.LEN_W(13), .FIFO_DEPTH(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .cfg_start    (cfg_start),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
        .err_tlast    (err_tlast),
        .bus          (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    int   cyc = 0, acks, beats, max_occ, done_cnt, done_cyc, start_cyc;
    int   rx_idx, rx_n, rx_tlast_at, cur_len, ret_delay = 1;
    bit   ack_en = 1, rst_drive = 1, start_pend = 0;
    bit   stall_seen, ever_rr, ever_wv, ever_tv;
    logic [3:0]  tready_pat = 4'b1111;
    logic [12:0] rd_addrs[$], wr_addr[$], pend_addr[$];
    logic [31:0] tx_data[$], wr_data[$];
    logic        tx_last[$];
    int          pend_due[$];

    function automatic logic [31:0] mem_word(input logic [12:0] a);
        return 32'hD00D_0000 | {19'd0, a};
    endfunction

    function automatic logic [31:0] rx_word(input int i);
        return 32'h5EED_0000 + 32'(i * 17);
    endfunction

    task automatic clear_obs();
        rd_addrs.delete(); wr_addr.delete(); wr_data.delete();
        tx_data.delete(); tx_last.delete();
        acks = 0; beats = 0; max_occ = 0; done_cnt = 0; done_cyc = 0; rx_idx = 0;
        stall_seen = 0; ever_rr = 0; ever_wv = 0; ever_tv = 0;
    endtask

    // One cycle: sample DUT at negedge, then drive inputs for the next posedge.
    task automatic step();
        int occ;
        @(negedge clk);
        cyc++;
        rst       = rst_drive;
        cfg_start = start_pend;
        start_pend = 0;
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (bus.dma_w_valid) begin
            wr_addr.push_back(bus.dma_w_addr);
            wr_data.push_back(bus.dma_w_data);
            ever_wv = 1;
        end
        if (bus.dma_r_ready) ever_rr = 1;
        if (bus.sm_tvalid)   ever_tv = 1;

        bus.dma_in_valid  = 1'b0;
        bus.brc_u0_data_o = '0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.dma_in_valid  = 1'b1;
            bus.brc_u0_data_o = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        bus.dma_r_ack = ack_en && bus.dma_r_ready;
        if (bus.dma_r_ack) begin
            rd_addrs.push_back(bus.dma_r_addr);
            pend_addr.push_back(bus.dma_r_addr);
            pend_due.push_back(cyc + ret_delay);
            acks++;
        end else if (busy && acks > 0 && acks < cur_len && !rst_drive) begin
            stall_seen = 1;
        end
        occ = acks - beats;
        if (occ > max_occ) max_occ = occ;

        bus.sm_tready = tready_pat[cyc % 4];
        if (bus.sm_tvalid && bus.sm_tready) begin
            tx_data.push_back(bus.sm_tdata);
            tx_last.push_back(bus.sm_tlast);
            beats++;
        end

        if (rx_idx < rx_n) begin
            bus.ss_tvalid = 1'b1;
            bus.ss_tdata  = rx_word(rx_idx);
            bus.ss_tlast  = (rx_idx == rx_tlast_at);
            if (bus.ss_tready) rx_idx++;
        end else begin
            bus.ss_tvalid = 1'b0;
            bus.ss_tdata  = '0;
            bus.ss_tlast  = 1'b0;
        end
    endtask

    task automatic run_xfer(input logic [12:0] src, input logic [12:0] dst,
                            input logic [12:0] len, input logic [3:0] pat, input int tl_idx);
        clear_obs();
        tready_pat  = pat;
        rx_n        = int'(len);
        cur_len     = int'(len);
        rx_tlast_at = tl_idx;
        cfg_src_base = src; cfg_dst_base = dst; cfg_len = len;
        start_pend = 1;
        step();
        start_cyc = cyc;
        @(posedge clk);
        #1;
        cfg_src_base = 13'h0555; cfg_dst_base = 13'h0AAA; cfg_len = 13'd9;
        for (int i = 0; i < 300 && done_cnt == 0; i++) step();
        step();
        step();
        chk("done_once", done_cnt, 1);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic check_data(input logic [12:0] src, input logic [12:0] dst, input int len);
        logic [12:0] a;
        chk("rd_count", rd_addrs.size(), len);
        chk("tx_count", tx_data.size(), len);
        chk("wr_count", wr_addr.size(), len);
        for (int i = 0; i < len; i++) begin
            a = src + 13'(i);
            if (i < rd_addrs.size()) chk("rd_addr", rd_addrs[i], a);
            if (i < tx_data.size()) begin
                chk("tx_data", tx_data[i], mem_word(a));
                chk("tx_last", tx_last[i], i == len - 1);
            end
            a = dst + 13'(i);
            if (i < wr_addr.size()) begin
                chk("wr_addr", wr_addr[i], a);
                chk("wr_data", wr_data[i], rx_word(i));
            end
        end
    endtask

    initial begin
        cfg_start = 0; cfg_src_base = '0; cfg_dst_base = '0; cfg_len = '0;
        bus.dma_r_ack = 0; bus.dma_in_valid = 0; bus.brc_u0_data_o = '0;
        bus.sm_tready = 0; bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.ss_tlast = 0;
        clear_obs();
        rx_n = 0; cur_len = 0;

        for (int i = 0; i < 3; i++) step();
        rst_drive = 0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_tlast, 0);
        chk("rst_r_ready", bus.dma_r_ready, 0);
        chk("rst_w_valid", bus.dma_w_valid, 0);
        chk("rst_sm_tvalid", bus.sm_tvalid, 0);
        chk("rst_ss_tready", bus.ss_tready, 0);

        // basic len=4, full-rate consumer
        run_xfer(13'h010, 13'h100, 13'd4, 4'b1111, 3);
        check_data(13'h010, 13'h100, 4);
        chk("t1_err", err_tlast, 0);

        // consumer ready 1-0-0-1: FIFO fills, requests stall
        run_xfer(13'h040, 13'h180, 13'd8, 4'b1001, 7);
        check_data(13'h040, 13'h180, 8);
        chk("t2_occ_max", max_occ, 4);
        chk("t2_rd_stall", stall_seen, 1);

        // address wrap at 8192
        run_xfer(13'h1FFE, 13'h1FFF, 13'd3, 4'b1111, 2);
        check_data(13'h1FFE, 13'h1FFF, 3);

        // zero length
        run_xfer(13'h020, 13'h020, 13'd0, 4'b1111, -1);
        chk("len0_latency", done_cyc - start_cyc, 1);
        chk("len0_no_rd", ever_rr, 0);
        chk("len0_no_wr", ever_wv, 0);
        chk("len0_no_tv", ever_tv, 0);

        // early tlast on beat 2
        run_xfer(13'h080, 13'h200, 13'd4, 4'b1111, 1);
        check_data(13'h080, 13'h200, 4);
        chk("tlast_err_set", err_tlast, 1);
        run_xfer(13'h000, 13'h000, 13'd0, 4'b1111, -1);
        chk("tlast_err_clr", err_tlast, 0);

        // reset mid-run with two reads outstanding
        clear_obs();
        ret_delay = 4; tready_pat = 4'b1111;
        rx_n = 4; rx_tlast_at = 3; cur_len = 4;
        cfg_src_base = 13'h020; cfg_dst_base = 13'h120; cfg_len = 13'd4;
        start_pend = 1;
        step();
        for (int i = 0; i < 40 && acks < 2; i++) step();
        chk("rst_two_acks", acks, 2);
        ack_en = 0; rst_drive = 1;
        step();
        rst_drive = 0; rx_n = 0;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_r_ready", bus.dma_r_ready, 0);
        chk("mid_rst_r_addr", bus.dma_r_addr, 0);
        chk("mid_rst_w_valid", bus.dma_w_valid, 0);
        chk("mid_rst_sm_tvalid", bus.sm_tvalid, 0);
        chk("mid_rst_sm_tlast", bus.sm_tlast, 0);
        chk("mid_rst_sm_tdata", bus.sm_tdata, 0);
        chk("mid_rst_ss_tready", bus.ss_tready, 0);
        ever_rr = 0; ever_wv = 0; ever_tv = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) step();
        chk("late_ret_drained", pend_addr.size(), 0);
        chk("late_ret_no_tv", ever_tv, 0);
        chk("late_ret_no_rd", ever_rr, 0);
        chk("late_ret_no_wr", ever_wv, 0);
        chk("late_ret_no_done", done_cnt, 0);
        ret_delay = 1; ack_en = 1;
        run_xfer(13'h030, 13'h140, 13'd4, 4'b1111, 3);
        check_data(13'h030, 13'h140, 4);
        chk("post_rst_err", err_tlast, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
